alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_shifter.sv | 58 +++++
 rtl/alu_core.sv | 112 +++++++++++
 tb/tb_alu_core.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, FSM state encodings and default datapath width.
// The control unit imports this package too, so its op code values must stay stable.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int SHAMT_W   = 5;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00011,
    OP_SLT  = 5'b00100,
    OP_SLTU = 5'b00101,
    OP_AND  = 5'b01010,
    OP_OR   = 5'b01100,
    OP_XOR  = 5'b01101,
    OP_SLL  = 5'b01110,
    OP_SRL  = 5'b01111,
    OP_SRA  = 5'b10000
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_HOLD  = 2'd3
  } alu_state_e;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative shifter for alu_core: moves the working register one bit per step.
// Direction and fill mode are latched on load, so later input changes cannot disturb a shift.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   value_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               left_i,
  input  logic               arith_i,
  input  logic               step_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               last_o
);

  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               left_q, arith_q;

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (step_i && (count_q != '0)) begin
      if (left_q) begin
        data_d = {data_q[WIDTH-2:0], 1'b0};
      end else begin
        data_d = {arith_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
      end
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      count_q <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= value_i;
      count_q <= shamt_i;
      left_q  <= left_i;
      arith_q <= arith_i;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // The step that consumes the final count is the one that hands control back to DONE.
  assign last_o = (count_q <= 5'd1);
  assign data_o = data_q;

endmodule

// File: rtl/alu_core.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, iterative shifts via alu_shifter,
// and a request/complete handshake that yields exactly one alu_valid pulse per request.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_en,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_valid,
  output logic             zero,
  output logic             illegal_op
);

  alu_state_e       state_q;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, zero_q, illegal_q, illegal_d, zero_d;

  logic               accept, acceptShift, shiftLast;
  logic [SHAMT_W-1:0] loadShamt;
  logic [WIDTH-1:0]   shiftData;

  assign accept      = (state_q == ST_IDLE) && alu_en;
  assign acceptShift = is_shift(alu_op) && (op_b[SHAMT_W-1:0] != '0);
  assign loadShamt   = acceptShift ? op_b[SHAMT_W-1:0] : '0;

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk     (clk),
    .rst_ni  (rst),
    .load_i  (accept),
    .value_i (op_a),
    .shamt_i (loadShamt),
    .left_i  (alu_op == OP_SLL),
    .arith_i (alu_op == OP_SRA),
    .step_i  (state_q == ST_SHIFT),
    .data_o  (shiftData),
    .last_o  (shiftLast)
  );

  // Result is formed from the captured operands, never the live inputs.
  always_comb begin
    result_d  = '0;
    illegal_d = 1'b0;
    case (op_q)
      OP_ADD:  result_d = a_q + b_q;
      OP_SUB:  result_d = a_q - b_q;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OP_AND:  result_d = a_q & b_q;
      OP_OR:   result_d = a_q | b_q;
      OP_XOR:  result_d = a_q ^ b_q;
      OP_SLL, OP_SRL, OP_SRA: result_d = shiftData;
      default: illegal_d = 1'b1;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (alu_en) begin
            op_q    <= alu_op;
            a_q     <= op_a;
            b_q     <= op_b;
            state_q <= acceptShift ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          if (shiftLast) state_q <= ST_DONE;
        end
        ST_DONE: begin
          result_q  <= result_d;
          valid_q   <= 1'b1;
          zero_q    <= zero_d;
          illegal_q <= illegal_d;
          state_q   <= ST_HOLD;
        end
        ST_HOLD: begin
          // A still-asserted request belongs to the completed operation; wait it out.
          if (!alu_en) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_result = result_q;
  assign alu_valid  = valid_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: scoreboard of expected results from an independent
// reference model, plus latency, single-pulse, and reset-abort scenarios.
module tb_alu_core;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [31:0] op_a, op_b;
  logic [31:0] alu_result;
  logic        alu_valid, zero, illegal_op;

  exp_t        sb[$];
  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] obsResult;
  logic        obsZero, obsIll;
  int          obsLat;
  int          extraPulses;

  alu_core #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_result (alu_result),
    .alu_valid  (alu_valid),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {illegal, result}.
  function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
    r   = 32'h0;
    ill = 1'b0;
    case (op)
      5'b00000: r = a + b;
      5'b00011: r = a - b;
      5'b00100: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b00101: r = (a < b) ? 32'd1 : 32'd0;
      5'b01010: r = a & b;
      5'b01100: r = a | b;
      5'b01101: r = a ^ b;
      5'b01110: r = a << b[4:0];
      5'b01111: r = a >> b[4:0];
      5'b10000: r = $unsigned($signed(a) >>> b[4:0]);
      default:  ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  // Drives one request, pushes its expectation, scrambles inputs after acceptance,
  // waits (bounded) for alu_valid, then keeps alu_en high holdCycles+1 cycles counting pulses.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int holdCycles);
    exp_t        e;
    logic [32:0] m;
    logic        seen;
    @(negedge clk);
    alu_op = op;
    op_a   = a;
    op_b   = b;
    alu_en = 1'b1;
    m      = model(op, a, b);
    e.res  = m[31:0];
    e.ill  = m[32];
    e.zero = (m[31:0] == 32'h0);
    e.lat  = ((op == 5'b01110 || op == 5'b01111 || op == 5'b10000) && b[4:0] != 5'd0) ? int'(b[4:0]) + 1 : 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    op_a   = $urandom;
    op_b   = $urandom;
    alu_op = 5'($urandom);
    obsLat = 0;
    seen   = 1'b0;
    while (!seen && obsLat < 64) begin
      @(posedge clk);
      obsLat++;
      @(negedge clk);
      if (alu_valid) seen = 1'b1;
    end
    obsResult   = alu_result;
    obsZero     = zero;
    obsIll      = illegal_op;
    extraPulses = 0;
    for (int i = 0; i <= holdCycles; i++) begin
      @(negedge clk);
      if (alu_valid) extraPulses++;
    end
    alu_en = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    alu_en = 1'b0;
    alu_op = 5'h0;
    op_a   = 32'h0;
    op_b   = 32'h0;
    repeat (3) @(negedge clk);
    assertCount++;
    if (alu_result !== 32'h0) begin failCount++; $display("[TB] FAIL reset_result: got %h expected %h", alu_result, 32'h0); end
    assertCount++;
    if (alu_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b expected 0", alu_valid); end
    assertCount++;
    if (zero !== 1'b0) begin failCount++; $display("[TB] FAIL reset_zero: got %b expected 0", zero); end
    assertCount++;
    if (illegal_op !== 1'b0) begin failCount++; $display("[TB] FAIL reset_illegal: got %b expected 0", illegal_op); end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [4:0]  ops [5];
    logic [31:0] as  [5];
    logic [31:0] bs  [5];
    exp_t        e;
    ops = '{5'b00000, 5'b10000, 5'b00100, 5'b00101, 5'b00000};
    as  = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF};
    bs  = '{32'h00000001, 32'h00000104, 32'h00000001, 32'h00000001, 32'h00000001};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(ops[i], as[i], bs[i], 0);
      e = sb.pop_front();
      assertCount++;
      if (obsResult !== e.res) begin failCount++; $display("[TB] FAIL directed%0d_result: got %h expected %h", i, obsResult, e.res); end
      assertCount++;
      if (obsZero !== e.zero) begin failCount++; $display("[TB] FAIL directed%0d_zero: got %b expected %b", i, obsZero, e.zero); end
      assertCount++;
      if (obsLat != e.lat) begin failCount++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, obsLat, e.lat); end
      assertCount++;
      if (extraPulses != 0) begin failCount++; $display("[TB] FAIL directed%0d_pulse: extra pulses %0d expected 0", i, extraPulses); end
    end
  endtask

  task automatic test_ops();
    logic [4:0]  ops [8];
    logic [31:0] as  [8];
    logic [31:0] bs  [8];
    exp_t        e;
    ops = '{5'b00011, 5'b01010, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b01110, 5'b10000};
    as  = '{32'h00000003, 32'hF0F0AAAA, 32'h0F0F0000, 32'hFFFF0000, 32'h00000001, 32'h80000001, 32'hDEADBEEF, 32'h7000000F};
    bs  = '{32'h00000005, 32'h0FF0FF00, 32'h000000F0, 32'h0F0F0F0F, 32'h0000001F, 32'hFFFFFFE1, 32'h00000020, 32'h00000003};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(ops[i], as[i], bs[i], 0);
      e = sb.pop_front();
      assertCount++;
      if (obsResult !== e.res) begin failCount++; $display("[TB] FAIL op%0d_result: got %h expected %h", i, obsResult, e.res); end
      assertCount++;
      if (obsLat != e.lat) begin failCount++; $display("[TB] FAIL op%0d_latency: got %0d expected %0d", i, obsLat, e.lat); end
      assertCount++;
      if (obsIll !== e.ill) begin failCount++; $display("[TB] FAIL op%0d_illegal: got %b expected %b", i, obsIll, e.ill); end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    applyStimulus(5'b01110, 32'h0000_00A5, 32'h0000_0003, 10);
    e = sb.pop_front();
    assertCount++;
    if (obsResult !== e.res) begin failCount++; $display("[TB] FAIL hold_result: got %h expected %h", obsResult, e.res); end
    assertCount++;
    if (extraPulses != 0) begin failCount++; $display("[TB] FAIL hold_pulses: extra pulses %0d expected 0", extraPulses); end
    assertCount++;
    if (alu_result !== e.res) begin failCount++; $display("[TB] FAIL hold_stable: got %h expected %h", alu_result, e.res); end
  endtask

  task automatic test_illegal();
    logic [4:0] ops [2];
    exp_t       e;
    ops = '{5'b00111, 5'b11111};
    for (int i = 0; i < 2; i++) begin
      applyStimulus(ops[i], 32'h1234_5678, 32'h0000_0009, 0);
      e = sb.pop_front();
      assertCount++;
      if (obsIll !== e.ill) begin failCount++; $display("[TB] FAIL illegal%0d_flag: got %b expected %b", i, obsIll, e.ill); end
      assertCount++;
      if (obsResult !== e.res) begin failCount++; $display("[TB] FAIL illegal%0d_result: got %h expected %h", i, obsResult, e.res); end
      assertCount++;
      if (obsZero !== e.zero) begin failCount++; $display("[TB] FAIL illegal%0d_zero: got %b expected %b", i, obsZero, e.zero); end
      assertCount++;
      if (obsLat != e.lat) begin failCount++; $display("[TB] FAIL illegal%0d_latency: got %0d expected %0d", i, obsLat, e.lat); end
    end
  endtask

  task automatic test_reset_mid_shift();
    int   pulses;
    exp_t e;
    applyStimulus(5'b00000, 32'h0000_0010, 32'h0000_0020, 0);
    void'(sb.pop_front());
    @(negedge clk);
    alu_op = 5'b01111;
    op_a   = 32'hFFFF_0000;
    op_b   = 32'h0000_0014;
    alu_en = 1'b1;
    @(posedge clk);
    #1;
    op_a = $urandom;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    assertCount++;
    if (alu_result !== 32'h0) begin failCount++; $display("[TB] FAIL rstmid_result: got %h expected %h", alu_result, 32'h0); end
    assertCount++;
    if ({alu_valid, zero, illegal_op} !== 3'b000) begin failCount++; $display("[TB] FAIL rstmid_flags: got %b expected 000", {alu_valid, zero, illegal_op}); end
    @(negedge clk);
    rst    = 1'b1;
    alu_en = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (alu_valid) pulses++;
    end
    assertCount++;
    if (pulses != 0) begin failCount++; $display("[TB] FAIL rstmid_nopulse: got %0d pulses expected 0", pulses); end
    applyStimulus(5'b00000, 32'd2, 32'd3, 0);
    e = sb.pop_front();
    assertCount++;
    if (obsResult !== 32'd5) begin failCount++; $display("[TB] FAIL rstmid_add_result: got %h expected %h", obsResult, 32'd5); end
    assertCount++;
    if (obsLat != e.lat) begin failCount++; $display("[TB] FAIL rstmid_add_latency: got %0d expected %0d", obsLat, e.lat); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  opList [10];
    logic [4:0]  op;
    logic [31:0] a, b;
    exp_t        e;
    opList = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01010, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000};
    for (int i = 0; i < 12; i++) begin
      op = opList[$urandom_range(9, 0)];
      a  = $urandom;
      b  = $urandom;
      applyStimulus(op, a, b, 0);
      e = sb.pop_front();
      assertCount++;
      if (obsResult !== e.res) begin failCount++; $display("[TB] FAIL b2b%0d_result op %b: got %h expected %h", i, op, obsResult, e.res); end
      assertCount++;
      if (obsLat != e.lat) begin failCount++; $display("[TB] FAIL b2b%0d_latency op %b: got %0d expected %0d", i, op, obsLat, e.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ops();
    test_hold();
    test_illegal();
    test_reset_mid_shift();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
